// File: rtl/bfsk_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : bfsk_pkg                                                    |
// | Shared sample width, byte size and FSM encoding for the demodulator. |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
package bfsk_pkg;

  localparam int SAMPLE_W      = 8;
  localparam int MID_DEFAULT   = 128;
  localparam int BITS_PER_BYTE = 8;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bfsk_demod_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : bfsk_demod_if                                               |
// | Sample stream in, decided bits and reassembled bytes out.            |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
interface bfsk_demod_if;
  import bfsk_pkg::*;

  logic [SAMPLE_W-1:0]      sample_in;
  logic                     sample_valid;
  logic                     start;
  logic                     busy;
  logic                     bit_out;
  logic                     bit_valid;
  logic [BITS_PER_BYTE-1:0] byte_out;
  logic                     byte_valid;

  modport master (
    output sample_in, sample_valid, start,
    input  busy, bit_out, bit_valid, byte_out, byte_valid
  );

  modport slave (
    input  sample_in, sample_valid, start,
    output busy, bit_out, bit_valid, byte_out, byte_valid
  );

endinterface
`default_nettype wire

// File: rtl/bfsk_demod_crossing_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : bfsk_crossing_counter                                       |
// | Hysteresis midscale-crossing detector with saturating count.         |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module bfsk_crossing_counter
  import bfsk_pkg::*;
#(
  parameter int MID   = MID_DEFAULT,
  parameter int HYST  = 4,
  parameter int CNT_W = 7
) (
  input  wire logic                clk,
  input  wire logic                reset,
  input  wire logic                clr_all,
  input  wire logic                clr_cnt,
  input  wire logic                en,
  input  wire logic [SAMPLE_W-1:0] sample_in,
  output logic      [CNT_W-1:0]    cnt_next
);

  // Two guard bits keep MID+HYST from wrapping in the comparison.
  localparam logic [SAMPLE_W+1:0] HI_LVL = (SAMPLE_W+2)'(MID + HYST);
  localparam logic [SAMPLE_W+1:0] LO_LVL = (SAMPLE_W+2)'(MID - HYST);

  logic             above_q, above_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SAMPLE_W+1:0] samp_ext;
  logic             flip;

  assign samp_ext = {2'b00, sample_in};

  always_comb begin
    above_d = above_q;
    if (en) begin
      if (samp_ext >= HI_LVL) begin
        above_d = 1'b1;
      end else if (samp_ext <= LO_LVL) begin
        above_d = 1'b0;
      end
    end
    if (clr_all) begin
      above_d = 1'b0;
    end
  end

  assign flip = en && !clr_all && (above_d != above_q);

  // cnt_next includes the current sample so the window's last crossing counts.
  always_comb begin
    cnt_next = cnt_q;
    if (flip && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_next = cnt_q + 1'b1;
    end
    cnt_d = (clr_all || clr_cnt) ? '0 : cnt_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      above_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      above_q <= above_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bfsk_demod.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : bfsk_demod                                                  |
// | BFSK bit decision by crossing count and MSB-first byte reassembly.   |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module bfsk_demod
  import bfsk_pkg::*;
#(
  parameter int SAMPLES_PER_BIT = 64,
  parameter int MID             = MID_DEFAULT,
  parameter int HYST            = 4,
  parameter int THRESH          = 10
) (
  input  wire logic    clk,
  input  wire logic    reset,
  bfsk_demod_if.slave  bus
);

  localparam int CNT_W = $clog2(SAMPLES_PER_BIT + 1);
  localparam int SC_W  = $clog2(SAMPLES_PER_BIT);
  localparam int BC_W  = $clog2(BITS_PER_BYTE);
  localparam logic [SC_W-1:0] LAST_SAMPLE = SC_W'(SAMPLES_PER_BIT - 1);
  localparam logic [BC_W-1:0] LAST_BIT    = BC_W'(BITS_PER_BYTE - 1);

  state_t state_q, state_d;

  logic [SC_W-1:0]          samp_cnt_q, samp_cnt_d;
  logic [BC_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic [BITS_PER_BYTE-1:0] shift_q, shift_d;
  logic [BITS_PER_BYTE-1:0] byte_out_q, byte_out_d;
  logic                     bit_out_q, bit_out_d;
  logic                     bit_valid_q, bit_valid_d;
  logic                     byte_valid_q, byte_valid_d;

  logic             sample_fire;
  logic             win_end;
  logic             decision;
  logic             clr_all;
  logic             clr_cnt;
  logic [CNT_W-1:0] cnt_next;

  assign sample_fire = (state_q == CAPTURE) && bus.sample_valid;
  assign win_end     = (samp_cnt_q == LAST_SAMPLE);
  assign decision    = int'(cnt_next) >= THRESH;

  bfsk_crossing_counter #(
    .MID   (MID),
    .HYST  (HYST),
    .CNT_W (CNT_W)
  ) u_xcnt (
    .clk       (clk),
    .reset     (reset),
    .clr_all   (clr_all),
    .clr_cnt   (clr_cnt),
    .en        (sample_fire),
    .sample_in (bus.sample_in),
    .cnt_next  (cnt_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (sample_fire && win_end && (bit_cnt_q == LAST_BIT)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    samp_cnt_d   = samp_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_out_d   = byte_out_q;
    bit_out_d    = bit_out_q;
    bit_valid_d  = 1'b0;
    byte_valid_d = 1'b0;
    clr_all      = 1'b0;
    clr_cnt      = 1'b0;

    if ((state_q == IDLE) && bus.start) begin
      clr_all    = 1'b1;
      samp_cnt_d = '0;
      bit_cnt_d  = '0;
      shift_d    = '0;
    end else if (sample_fire) begin
      if (win_end) begin
        clr_cnt     = 1'b1;
        samp_cnt_d  = '0;
        bit_cnt_d   = bit_cnt_q + 1'b1;
        bit_out_d   = decision;
        bit_valid_d = 1'b1;
        shift_d     = {shift_q[BITS_PER_BYTE-2:0], decision};
        if (bit_cnt_q == LAST_BIT) begin
          byte_out_d   = {shift_q[BITS_PER_BYTE-2:0], decision};
          byte_valid_d = 1'b1;
        end
      end else begin
        samp_cnt_d = samp_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samp_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      byte_out_q   <= '0;
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
      byte_valid_q <= 1'b0;
    end else begin
      samp_cnt_q   <= samp_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_out_q   <= byte_out_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
      byte_valid_q <= byte_valid_d;
    end
  end

  // busy drops on the same edge that registers byte_valid.
  assign bus.busy       = (state_q == CAPTURE);
  assign bus.bit_out    = bit_out_q;
  assign bus.bit_valid  = bit_valid_q;
  assign bus.byte_out   = byte_out_q;
  assign bus.byte_valid = byte_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_bfsk_demod.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_bfsk_demod                                               |
// | Scoreboard bench: tone windows in, decided bits/bytes checked out.   |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_bfsk_demod;
  import bfsk_pkg::*;

  localparam int SPB = 64;

  typedef struct { logic b;         int cyc; } bit_exp_t;
  typedef struct { logic [7:0] v;   int cyc; } byte_exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   junk_cyc;

  bit_exp_t  bit_q[$];
  byte_exp_t byte_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bfsk_demod_if bus();

  bfsk_demod #(
    .SAMPLES_PER_BIT (SPB),
    .MID             (128),
    .HYST            (4),
    .THRESH          (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Code 0: period-32 low tone, 1: period-8 high tone, 2: inside band, 3: exactly 10 crossings.
  function automatic logic [7:0] tone(input logic [1:0] code, input int k);
    case (code)
      2'd0:    return ((k % 32) < 16) ? 8'd200 : 8'd56;
      2'd1:    return ((k % 8) < 4) ? 8'd200 : 8'd56;
      2'd2:    return ((k % 2) != 0) ? 8'd130 : 8'd126;
      default: return (k < 10) ? (((k % 2) == 0) ? 8'd200 : 8'd56) : 8'd56;
    endcase
  endfunction

  task automatic drive_sample(input logic [7:0] s, input int gap, input logic st, output int at_cyc);
    @(posedge clk); #1;
    bus.sample_valid = 1'b1;
    bus.sample_in    = s;
    bus.start        = st;
    at_cyc           = cyc;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      bus.sample_valid = 1'b0;
      bus.start        = 1'b0;
      bus.sample_in    = 8'($urandom);
    end
  endtask

  task automatic send_byte(input logic [15:0] codes, input int gap, input int restart_bit, input int stop_bits);
    logic [7:0] expv;
    logic [1:0] c;
    logic       b;
    int         last;
    @(posedge clk); #1;
    bus.start        = 1'b1;
    bus.sample_valid = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_eq("busy_after_start", bus.busy, 1);
    expv = '0;
    for (int i = 0; i < 8; i++) begin
      c = codes[15-2*i -: 2];
      b = (c == 2'd1) || (c == 2'd3);
      if (i == stop_bits) begin
        for (int k = 0; k < 10; k++) drive_sample(tone(c, k), gap, 1'b0, last);
        return;
      end
      for (int k = 0; k < SPB; k++)
        drive_sample(tone(c, k), gap, (i == restart_bit) && (k == 0), last);
      expv = {expv[6:0], b};
      bit_q.push_back('{b, last + 1});
      if (i == 7) byte_q.push_back('{expv, last + 1});
    end
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    bus.start        = 1'b0;
  endtask

  always @(negedge clk) begin
    if (bus.bit_valid) begin
      check_eq("bit_q_depth", (bit_q.size() > 0) ? 32'd1 : 32'd0, 1);
      if (bit_q.size() > 0) begin
        bit_exp_t e;
        e = bit_q.pop_front();
        check_eq("bit_value", bus.bit_out, e.b);
        check_eq("bit_latency", cyc, e.cyc);
      end
    end
    if (bus.byte_valid) begin
      check_eq("byte_q_depth", (byte_q.size() > 0) ? 32'd1 : 32'd0, 1);
      check_eq("byte_with_bit_valid", bus.bit_valid, 1);
      check_eq("busy_at_byte", bus.busy, 0);
      if (byte_q.size() > 0) begin
        byte_exp_t e;
        e = byte_q.pop_front();
        check_eq("byte_value", bus.byte_out, e.v);
        check_eq("byte_latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_in    = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy",       bus.busy, 0);
    check_eq("rst_bit_out",    bus.bit_out, 0);
    check_eq("rst_bit_valid",  bus.bit_valid, 0);
    check_eq("rst_byte_out",   bus.byte_out, 8'h00);
    check_eq("rst_byte_valid", bus.byte_valid, 0);
    reset = 1'b0;

    // 8'h99: high tone first window, low/high tones after.
    send_byte(16'h4141, 0, -1, 8);

    // Valid samples in IDLE must be ignored; then threshold-edge and in-band windows.
    for (int k = 0; k < 70; k++) drive_sample(8'd200, 0, 1'b0, junk_cyc);
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    check_eq("idle_busy", bus.busy, 0);
    send_byte(16'hE463, 0, -1, 8);

    // 8'hA5 with sample_valid every other cycle.
    send_byte(16'h4411, 1, -1, 8);

    // 8'h3C aborted by reset after three bits, then sent in full.
    send_byte(16'h0550, 0, -1, 3);
    @(posedge clk); #1;
    reset            = 1'b1;
    bus.sample_valid = 1'b0;
    #1;
    check_eq("abort_busy",       bus.busy, 0);
    check_eq("abort_bit_out",    bus.bit_out, 0);
    check_eq("abort_bit_valid",  bus.bit_valid, 0);
    check_eq("abort_byte_out",   bus.byte_out, 8'h00);
    check_eq("abort_byte_valid", bus.byte_valid, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    send_byte(16'h0550, 0, -1, 8);

    // 8'h5A with a start pulse at the beginning of bit 4.
    send_byte(16'h1144, 0, 4, 8);

    repeat (4) @(posedge clk);
    #1;
    check_eq("bits_drained",  bit_q.size(), 0);
    check_eq("bytes_drained", byte_q.size(), 0);
    check_eq("byte_out_hold", bus.byte_out, 8'h5A);
    check_eq("bit_out_hold",  bus.bit_out, 0);
    check_eq("final_busy",    bus.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
